// File: rtl/au_issue_q_if.sv
// Handshake bus between an op producer, the issue queue and the arithmetic unit.
// The slave modport is the queue's view; the master modport is the producer/consumer side.
interface au_issue_q_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_typ;
    logic [1:0]        in_code;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_typ;
    logic [1:0]        out_code;
    logic              div_zero;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_a, in_b, in_typ, in_code, out_ready,
        output in_ready, out_valid, out_a, out_b, out_typ, out_code, div_zero, count
    );

    modport master (
        output in_valid, in_a, in_b, in_typ, in_code, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_typ, out_code, div_zero, count
    );
endinterface

// File: rtl/au_issue_q.sv
// First-word fall-through issue queue feeding the arithmetic unit.
// Divide-by-zero is flagged at push time and travels with each entry.
module au_issue_q #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    au_issue_q_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              dz;
        logic [1:0]        code;
        logic              typ;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_push;
    logic   w_pop;
    entry_t w_wr;
    entry_t w_head;

    assign w_in_ready  = r_count < CNT_W'(DEPTH);
    assign w_out_valid = r_count != '0;
    // Flush wins over any handshake in the same cycle.
    assign w_push      = bus.in_valid & w_in_ready & ~flush;
    assign w_pop       = w_out_valid & bus.out_ready & ~flush;

    always_comb begin
        w_wr      = '0;
        w_wr.a    = bus.in_a;
        w_wr.b    = bus.in_b;
        w_wr.typ  = bus.in_typ;
        w_wr.code = bus.in_code;
        w_wr.dz   = (bus.in_code == 2'b11) && (bus.in_b == '0);
    end

    // Payload storage is never reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_head = '0;
        if (w_out_valid) begin
            w_head = r_mem[r_rptr];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_a     = w_head.a;
    assign bus.out_b     = w_head.b;
    assign bus.out_typ   = w_head.typ;
    assign bus.out_code  = w_head.code;
    assign bus.div_zero  = w_head.dz;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_au_issue_q.sv
// Directed bench for au_issue_q with a queue-based scoreboard of expected head ops.
module tb_au_issue_q;
    logic clk;
    logic rst;
    logic flush;

    au_issue_q_if #(.DATA_W(8), .DEPTH(4)) bus ();

    au_issue_q #(.DATA_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       typ;
        logic [1:0] code;
    } op_t;

    op_t sb[$];
    int  vectors = 0;
    int  errs    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the scoreboard state.
    task automatic check_outputs(input string tag);
        logic       dz;
        chk({tag, ".count"}, 32'(bus.count), 32'(sb.size()));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(sb.size() < 4));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            dz = (sb[0].code == 2'b11) && (sb[0].b == 8'h00);
            chk({tag, ".out_a"}, 32'(bus.out_a), 32'(sb[0].a));
            chk({tag, ".out_b"}, 32'(bus.out_b), 32'(sb[0].b));
            chk({tag, ".out_typ"}, 32'(bus.out_typ), 32'(sb[0].typ));
            chk({tag, ".out_code"}, 32'(bus.out_code), 32'(sb[0].code));
            chk({tag, ".div_zero"}, 32'(bus.div_zero), 32'(dz));
        end else begin
            chk({tag, ".out_a0"}, 32'(bus.out_a), 32'd0);
            chk({tag, ".out_b0"}, 32'(bus.out_b), 32'd0);
            chk({tag, ".out_typ0"}, 32'(bus.out_typ), 32'd0);
            chk({tag, ".out_code0"}, 32'(bus.out_code), 32'd0);
            chk({tag, ".div_zero0"}, 32'(bus.div_zero), 32'd0);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, update scoreboard, advance to edge+1.
    task automatic cycle(input string tag, input logic vld, input logic [7:0] a,
                         input logic [7:0] b, input logic typ, input logic [1:0] code,
                         input logic ordy, input logic fl);
        op_t op;
        bit  do_push;
        bit  do_pop;
        bus.in_valid  = vld;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_typ    = typ;
        bus.in_code   = code;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check_outputs(tag);
        do_push = vld && (sb.size() < 4);
        do_pop  = ordy && (sb.size() != 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                op.a = a; op.b = b; op.typ = typ; op.code = code;
                sb.push_back(op);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic ordy);
        cycle(tag, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, ordy, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_typ    = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1;
        check_outputs("reset_edge");
        rst = 1'b0;

        // Single push into empty queue, head held while stalled
        cycle("push1", 1'b1, 8'd5, 8'd3, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("hold", 1'b0);
        idle("drain1", 1'b1);
        idle("empty1", 1'b0);

        // Fill to full, reject fifth push, pop frees a slot
        for (int i = 0; i < 4; i++)
            cycle("fill", 1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 1'(i), 2'(i), 1'b0, 1'b0);
        cycle("full_reject", 1'b1, 8'hEE, 8'hEE, 1'b1, 2'b01, 1'b0, 1'b0);
        cycle("full_pop", 1'b1, 8'hDD, 8'hDD, 1'b0, 2'b10, 1'b1, 1'b0);
        idle("after_pop", 1'b0);
        for (int i = 0; i < 3; i++) idle("drain2", 1'b1);
        idle("empty2", 1'b0);

        // Streaming push+pop with pointer wrap
        cycle("stream_pre", 1'b1, 8'($urandom), 8'($urandom), 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            cycle("stream", 1'b1, 8'($urandom), 8'($urandom), 1'(i % 2), 2'(i % 4), 1'b1, 1'b0);
        idle("stream_drain", 1'b1);
        idle("empty3", 1'b0);

        // Divide-by-zero flag travels with its own entry only
        cycle("dz_push0", 1'b1, 8'h80, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0);
        cycle("dz_push1", 1'b1, 8'h07, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0);
        idle("dz_head0", 1'b1);
        idle("dz_head1", 1'b1);
        idle("empty4", 1'b0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++)
            cycle("pre_flush", 1'b1, 8'(8'h30 + i), 8'(8'h40 + i), 1'b0, 2'b01, 1'b0, 1'b0);
        cycle("flush", 1'b1, 8'h99, 8'h99, 1'b1, 2'b00, 1'b1, 1'b1);
        idle("post_flush", 1'b0);

        // Asynchronous reset between edges
        cycle("pre_rst0", 1'b1, 8'h51, 8'h52, 1'b0, 2'b00, 1'b0, 1'b0);
        cycle("pre_rst1", 1'b1, 8'h61, 8'h62, 1'b1, 2'b01, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        check_outputs("count2");
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check_outputs("async_rst");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle("post_rst_push", 1'b1, 8'h71, 8'h72, 1'b0, 2'b10, 1'b0, 1'b0);
        idle("post_rst_head", 1'b1);
        idle("final", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
